// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared definitions for the VGA raster timing generator:
//   - state_t: raster FSM states (S_OFF / S_RUN / S_DRAIN)
//   - CTRL_*: bit positions inside the reg0 control word
//   - CNT_W / CNT_MAX: raster counter width and its range
//   - DEF_*: default 640x480@60 timing, in pixels and lines
package vga_timing_pkg;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_HPOL   = 1;
    localparam int CTRL_VPOL   = 2;
    localparam int CTRL_IRQACK = 3;

    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_sync_decode.sv
// vga_sync_decode
//   Decodes one raster axis (horizontal or vertical) from its counter.
//   Parameters: ACTIVE, FP, SYNC -- visible length, front porch and sync
//   width of the axis, in counter units.
//   Ports:
//     count      in   CNT_W  current axis counter
//     pol        in   1      asserted level of sync (0 = active-low)
//     sync       out  1      sync at its asserted level inside the window
//                            [ACTIVE+FP, ACTIVE+FP+SYNC), inactive elsewhere
//     in_active  out  1      count < ACTIVE
module vga_sync_decode
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC
) (
    input  logic [CNT_W-1:0] count,
    input  logic             pol,
    output logic             sync,
    output logic             in_active
);

    // One extra bit so a window ending exactly at CNT_MAX does not wrap to 0.
    typedef logic [CNT_W:0] ext_t;

    localparam ext_t ACT_END    = ext_t'(ACTIVE);
    localparam ext_t SYNC_START = ext_t'(ACTIVE + FP);
    localparam ext_t SYNC_END   = ext_t'(ACTIVE + FP + SYNC);

    logic in_sync;

    always_comb begin
        in_active = ({1'b0, count} < ACT_END);
        in_sync   = ({1'b0, count} >= SYNC_START) && ({1'b0, count} < SYNC_END);
        sync      = in_sync ? pol : ~pol;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator. Walks x/y over H_TOTAL x V_TOTAL on each pixel
//   strobe, produces sync/de/frame_start, and latches the framebuffer base
//   only at frame boundaries so mid-frame register writes never tear.
//   Optional feature macro: VGA_TIMING_FRAME_IRQ_EN adds a sticky irq output.
//   Ports:
//     clk          in   1   system clock
//     reset        in   1   synchronous, active-high
//     pix_en       in   1   pixel strobe; counters advance only when high
//     ctrl         in   32  bit0 enable, bit1 hsync pol, bit2 vsync pol,
//                           bit3 irq ack (level)
//     fb_base_in   in   32  framebuffer base address (reg1)
//     hsync/vsync  out  1   sync outputs, polarity from ctrl
//     de           out  1   data enable, x<H_ACTIVE && y<V_ACTIVE while running
//     x, y         out  10  raster counters
//     frame_start  out  1   one-clk pulse when a frame begins at (0,0)
//     fb_base      out  32  base address latched at frame_start
//     running      out  1   FSM in S_RUN or S_DRAIN
//     irq          out  1   (VGA_TIMING_FRAME_IRQ_EN only) sticky frame flag
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [31:0] ctrl,
    input  logic [31:0] fb_base_in,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        frame_start,
    output logic [31:0] fb_base,
    output logic        running
`ifdef VGA_TIMING_FRAME_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds the 10-bit counter range");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  x_d, y_d, x_step, y_step;
    logic              frame_start_d, running_d;
    logic [31:0]       fb_base_d;
    logic              en, end_of_line, end_of_frame;
    logic              h_active, v_active;

    assign en           = ctrl[CTRL_EN];
    assign end_of_line  = (x == H_LAST);
    assign end_of_frame = end_of_line && (y == V_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        x_step        = end_of_line ? '0 : x + 10'd1;
        y_step        = end_of_line ? ((y == V_LAST) ? '0 : y + 10'd1) : y;
        state_d       = state_q;
        x_d           = x;
        y_d           = y;
        frame_start_d = 1'b0;
        fb_base_d     = fb_base;

        unique case (state_q)
            S_OFF: begin
                x_d = '0;
                y_d = '0;
                // The first strobe with enable starts a frame in place at (0,0).
                if (pix_en && en) begin
                    state_d       = S_RUN;
                    frame_start_d = 1'b1;
                    fb_base_d     = fb_base_in;
                end
            end
            S_RUN, S_DRAIN: begin
                if (pix_en) begin
                    x_d = x_step;
                    y_d = y_step;
                end
                // A new frame only begins if enable is still (or again) set
                // at the wrap; a draining frame just lands on (0,0) in S_OFF.
                if (pix_en && end_of_frame && en) begin
                    frame_start_d = 1'b1;
                    fb_base_d     = fb_base_in;
                end
                if (en)
                    state_d = S_RUN;
                else if (pix_en && end_of_frame)
                    state_d = S_OFF;
                else
                    state_d = S_DRAIN;
            end
            default: state_d = S_OFF;
        endcase

        running_d = (state_d != S_OFF);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_OFF;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            fb_base     <= '0;
            running     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x           <= x_d;
            y           <= y_d;
            frame_start <= frame_start_d;
            fb_base     <= fb_base_d;
            running     <= running_d;
        end
    end

    // Sync and active flags decode the registered counters directly, so they
    // always match the x/y on the outputs; polarity bits act at once.
    vga_sync_decode #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC)
    ) u_h_decode (
        .count     (x),
        .pol       (ctrl[CTRL_HPOL]),
        .sync      (hsync),
        .in_active (h_active)
    );

    vga_sync_decode #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC)
    ) u_v_decode (
        .count     (y),
        .pol       (ctrl[CTRL_VPOL]),
        .sync      (vsync),
        .in_active (v_active)
    );

    // Counters rest at (0,0) in S_OFF, which would decode as visible.
    assign de = running && h_active && v_active;

`ifdef VGA_TIMING_FRAME_IRQ_EN
    logic unused_ctrl;
    assign unused_ctrl = ^ctrl[31:4];

    // Set takes priority over the level acknowledge.
    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else if (frame_start && running)
            irq <= 1'b1;
        else if (ctrl[CTRL_IRQACK])
            irq <= 1'b0;
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = ^ctrl[31:3];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench. dut_def runs the default 640x480 timing for one line;
//   dut runs a reduced raster (15 x 11) so whole frames stay short:
//   H: active 8, fp 2, sync 3, bp 2 -> hsync on x = 10..12
//   V: active 6, fp 2, sync 1, bp 2 -> vsync on y = 8; 165 pixels per frame
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic [31:0] ctrl = '0;
    logic [31:0] fb_base_in = '0;

    logic        hsync, vsync, de, frame_start, running;
    logic [9:0]  x, y;
    logic [31:0] fb_base;

    logic        d_hsync, d_vsync, d_de, d_frame_start, d_running;
    logic [9:0]  d_x, d_y;
    logic [31:0] d_fb_base;

`ifdef VGA_TIMING_FRAME_IRQ_EN
    logic        irq, d_irq;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (1), .V_BP (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .ctrl        (ctrl),
        .fb_base_in  (fb_base_in),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .fb_base     (fb_base),
        .running     (running)
`ifdef VGA_TIMING_FRAME_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    vga_timing_gen dut_def (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .ctrl        (ctrl),
        .fb_base_in  (fb_base_in),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .de          (d_de),
        .x           (d_x),
        .y           (d_y),
        .frame_start (d_frame_start),
        .fb_base     (d_fb_base),
        .running     (d_running)
`ifdef VGA_TIMING_FRAME_IRQ_EN
        ,
        .irq         (d_irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobe; outputs are read 1 ns after the edge.
    task automatic tick(input logic en);
        pix_en = en;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
    endtask

    task automatic adv(input int n);
        repeat (n) tick(1'b1);
    endtask

    int hs_cnt, hs_first, hs_last;
    int de_cnt, hs_low, vs_low, vs_min, vs_max, fs_cnt;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick(1'b0);
        reset = 1'b0;
        tick(1'b0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_de", de, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_running", running, 0);
        check("rst_fb_base", fb_base, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);

        // ---------------- start, pix_en every 2nd clk ----------------
        fb_base_in = 32'h0000_A000;
        ctrl = 32'h1;
        tick(1'b0);
        check("no_start_without_pix", running, 0);
        tick(1'b1);
        check("start_frame_start", frame_start, 1);
        check("start_x", x, 0);
        check("start_y", y, 0);
        check("start_running", running, 1);
        check("start_fb_base", fb_base, 32'h0000_A000);
        check("start_de", de, 1);
        tick(1'b0);
        check("frame_start_clears", frame_start, 0);

        // Default timing: one full 800-pixel line.
        hs_cnt = 0; hs_first = 1023; hs_last = 0;
        for (int i = 0; i < 800; i++) begin
            tick(1'b1);
            if (d_hsync == 1'b0) begin
                hs_cnt++;
                if (int'(d_x) < hs_first) hs_first = int'(d_x);
                if (int'(d_x) > hs_last)  hs_last  = int'(d_x);
            end
            tick(1'b0);
        end
        check("def_hsync_width", hs_cnt, 96);
        check("def_hsync_first_x", hs_first, 656);
        check("def_hsync_last_x", hs_last, 751);
        check("def_line_wrap_x", d_x, 0);
        check("def_line_wrap_y", d_y, 1);

        // ---------------- reduced raster, consecutive pix_en ----------------
        reset = 1'b1;
        tick(1'b1);
        reset = 1'b0;
        check("reset_beats_pix_x", x, 0);
        check("reset_beats_pix_running", running, 0);
        tick(1'b1);
        check("frame1_start", frame_start, 1);

        de_cnt = int'(de); hs_low = 0; vs_low = 0; vs_min = 1023; vs_max = 0; fs_cnt = 0;
        for (int i = 1; i < 165; i++) begin
            tick(1'b1);
            de_cnt += int'(de);
            if (!hsync) hs_low++;
            if (!vsync) begin
                vs_low++;
                if (int'(y) < vs_min) vs_min = int'(y);
                if (int'(y) > vs_max) vs_max = int'(y);
            end
            fs_cnt += int'(frame_start);
        end
        check("frame_de_count", de_cnt, 48);
        check("frame_hsync_low", hs_low, 33);
        check("frame_vsync_low", vs_low, 15);
        check("vsync_first_y", vs_min, 8);
        check("vsync_last_y", vs_max, 8);
        check("no_midframe_start", fs_cnt, 0);
        check("frame_last_x", x, 14);
        check("frame_last_y", y, 10);
        tick(1'b1);
        check("frame2_start", frame_start, 1);
        check("frame2_x", x, 0);
        check("frame2_y", y, 0);

        // ---------------- deferred fb_base ----------------
        adv(45);
        fb_base_in = 32'h0010_0000;
`ifdef VGA_TIMING_FRAME_IRQ_EN
        check("irq_set_after_start", irq, 1);
        ctrl = 32'h9;
        tick(1'b0);
        check("irq_ack_alone", irq, 0);
        ctrl = 32'h1;
`endif
        adv(1);
        check("fb_base_deferred", fb_base, 32'h0000_A000);
        adv(118);
        check("pre_wrap_x", x, 14);
        check("pre_wrap_fb_base", fb_base, 32'h0000_A000);
        adv(1);
        check("frame3_start", frame_start, 1);
        check("fb_base_updated", fb_base, 32'h0010_0000);
`ifdef VGA_TIMING_FRAME_IRQ_EN
        ctrl = 32'h9;
        tick(1'b0);
        check("irq_set_wins", irq, 1);
        ctrl = 32'h1;
`endif
        tick(1'b0);
        check("hold_x", x, 0);
        check("hold_frame_start", frame_start, 0);
        check("hold_de", de, 1);

        // ---------------- enable toggle and drain ----------------
        adv(40);
        check("mid_hsync_active_low", hsync, 0);
        ctrl = 32'h0;
        tick(1'b0);
        check("drain_running", running, 1);
        ctrl = 32'h1;
        tick(1'b0);
        ctrl = 32'h0;
        tick(1'b0);
        adv(5);
        check("drain_x", x, 0);
        check("drain_y", y, 3);
        ctrl = 32'h1;
        adv(120);
        check("rerun_frame_start", frame_start, 1);
        check("rerun_x", x, 0);
        adv(30);
        ctrl = 32'h0;
        adv(134);
        check("drain_end_x", x, 14);
        check("drain_end_y", y, 10);
        check("drain_end_running", running, 1);
        adv(1);
        check("off_x", x, 0);
        check("off_y", y, 0);
        check("off_running", running, 0);
        check("off_no_frame_start", frame_start, 0);
        check("off_de", de, 0);
        check("off_hsync", hsync, 1);
        check("off_vsync", vsync, 1);
        adv(3);
        check("off_hold_x", x, 0);

        // ---------------- active-high polarity, reset mid-frame ----------------
        ctrl = 32'h7;
        tick(1'b0);
        check("pol_idle_hsync", hsync, 0);
        check("pol_idle_vsync", vsync, 0);
        tick(1'b1);
        check("pol_start", frame_start, 1);
        adv(10);
        check("pol_hsync_pulse", hsync, 1);
        adv(110);
        check("pol_vsync_pulse", vsync, 1);
        check("pol_hsync_idle_x0", hsync, 0);
        adv(5);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        check("midrst_x", x, 0);
        check("midrst_y", y, 0);
        check("midrst_de", de, 0);
        check("midrst_frame_start", frame_start, 0);
        check("midrst_running", running, 0);
        check("midrst_fb_base", fb_base, 0);
        check("midrst_hsync", hsync, 0);
        check("midrst_vsync", vsync, 0);
        check("midrst_def_x", d_x, 0);
        check("midrst_def_running", d_running, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the video IP, directly downstream of the Avalon MM slave register block. It consumes the control registers (reg0 control, reg1 framebuffer base) and produces VGA sync, data-enable and pixel coordinates for the pixel-fetch/output stage. Register changes are applied at frame boundaries to avoid tearing. Pixel rate is set by an external one-cycle strobe on the single system clock.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal front porch, sync and back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical front porch, sync and back porch, in lines
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- pix_en  in  1  pixel strobe; counters advance only on cycles where it is high
- ctrl  in  32  reg0: bit0 enable, bit1 hsync active-high, bit2 vsync active-high, bit3 irq_ack (level)
- fb_base_in  in  32  reg1: framebuffer base address
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  high while (x<H_ACTIVE && y<V_ACTIVE)
- x  out  10  horizontal counter
- y  out  10  vertical counter
- frame_start  out  1  one-cycle pulse at x=0,y=0
- fb_base  out  32  frame-latched base address
- running  out  1  high in S_RUN and S_DRAIN

## Operation
- FSM states: S_OFF, S_RUN, S_DRAIN.
  - S_OFF: counters held at 0; sync outputs at their inactive level; de=0.
    - Go to S_RUN on the first pix_en with ctrl[0]=1. On that same edge: counters stay at 0, frame_start=1, fb_base<=fb_base_in.
  - S_RUN: on each pix_en, x increments.
    - At x = H_TOTAL-1, x wraps to 0 and y increments.
    - At y = V_TOTAL-1 with x at end of line, y wraps to 0, frame_start pulses, and fb_base latches fb_base_in.
    - If ctrl[0]=0 is sampled, go to S_DRAIN.
  - S_DRAIN: the frame completes normally, with no new frame_start.
    - At the end of the frame, go to S_OFF.
    - ctrl[0]=1 during S_DRAIN returns the FSM to S_RUN without a gap.
- H_TOTAL = sum of the H_ parameters (800). V_TOTAL = sum of the V_ parameters (525). Both counters are 10 bits, and elaboration fails if either total exceeds 1024.
- hsync is asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync is asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Asserted level is given by ctrl[1] for hsync and ctrl[2] for vsync (0 = active-low). Polarity bits apply immediately.
- fb_base changes only at frame_start. Mid-frame writes to reg1 are deferred.

## Timing
- All outputs are registered and updated on the same pix_en edge as x/y. hsync/vsync/de always correspond to the x/y values presented in the same cycle.
- Cycles with pix_en=0 hold every output unchanged, except that frame_start is a one-clk pulse that then clears.
- Reset values: x=0, y=0, de=0, frame_start=0, running=0, fb_base=0, state=S_OFF. hsync=1 and vsync=1, which is the inactive level for the reset ctrl (active-low).
- Reset mid-frame aborts immediately to the reset values. There is no drain.
- Enable toggled 1→0→1 within one frame: the FSM stays in, or returns to, S_RUN. Raster continuity is preserved.
- pix_en high on consecutive clk cycles is legal: the generator runs at clk rate.

## Configuration
- VGA_TIMING_FRAME_IRQ_EN defined: adds output irq (1 bit).
  - Sticky flag, set on each frame_start while running.
  - Cleared on any cycle where ctrl[3]=1.
  - Simultaneous set and clear: set wins.
  - Reset value 0.
- Undefined: no irq port and no flag logic. ctrl[3] is ignored.

## Structure
- Package vga_timing_pkg holds:
  - state enum (S_OFF/S_RUN/S_DRAIN)
  - ctrl bit index constants (CTRL_EN=0, CTRL_HPOL=1, CTRL_VPOL=2, CTRL_IRQACK=3)
  - default 640x480 timing constants
- One sub-module, vga_sync_decode: given counter, active/fp/sync parameters and polarity, it produces the sync and in-active signals. It is instantiated once for the horizontal axis and once for the vertical axis.

## Test plan
- Reset, then ctrl=1 with pix_en every 2nd clk -> frame_start at x=0,y=0; hsync low for exactly 96 pix_en at x=656..751; line period 800 pix_en.
- Full frame -> vsync low on y=490..491; de high for 640x480=307200 pix_en; frame_start every 420000 pix_en.
- Write fb_base_in=0x00100000 at y=100 -> fb_base stays at its old value until the next frame_start, then reads 0x00100000.
- ctrl 1→0 at y=200 -> frame completes through y=524, x=799, then S_OFF: x=y=0, running=0, hsync=vsync=1.
- ctrl=0x7 (both polarities active-high) -> sync idle at 0, pulses high. Reset asserted at x=300,y=50 -> next cycle all outputs are at their reset values.
- With VGA_TIMING_FRAME_IRQ_EN: irq=1 after frame_start; ctrl[3]=1 pulsed in the same cycle as a frame_start -> irq stays 1; pulsed alone -> irq=0.
